fetch_prefetch_unit: RTL and testbench

//   Instruction prefetch stage between the PC/instruction memory and the fetch-decode pipeline registers.

---
 rtl/fetch_prefetch_unit.sv | 161 ++++++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetch stage.
// Issues in-order reads on a req/gnt/rvalid handshake to instruction memory.
// Returned words are queued together with their PCs. Decode sees the queue
// head through a first-word-fall-through valid/ready interface.
// A taken-branch redirect flushes the queue, marks every read still in flight
// as stale, and restarts fetch at the target PC.
module fetch_prefetch_unit #(
   parameter int          DEPTH    = 4,
   parameter int          MAX_OUT  = 2,
   parameter logic [15:0] PC_INC   = 16'd2,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic                   clock,
   input  logic                   rst,
   input  logic                   redirect,
   input  logic [15:0]            redirect_pc,
   output logic                   imem_req,
   output logic [15:0]            imem_addr,
   input  logic                   imem_gnt,
   input  logic                   imem_rvalid,
   input  logic [15:0]            imem_rdata,
   output logic                   dec_valid,
   output logic [15:0]            dec_ir,
   output logic [15:0]            dec_pc,
   input  logic                   dec_ready,
   output logic [$clog2(DEPTH):0] occupancy
);

   localparam int AW = $clog2(DEPTH);                   // queue pointer width
   localparam int CW = AW + 1;                          // queue count width
   localparam int OW = $clog2(MAX_OUT + 1);             // in-flight count width
   localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam int RW = AW + 2;                          // reservation sum width

   localparam logic [OW-1:0] MAX_OUT_C = OW'(MAX_OUT);
   localparam logic [RW-1:0] DEPTH_R   = RW'(DEPTH);
   localparam logic [TW-1:0] TAG_LAST  = TW'(MAX_OUT - 1);

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] ir;
   } entry_t;

   logic [15:0]   fetch_pc_q, fetch_pc_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [OW-1:0] out_cnt_q, out_cnt_d;
   logic [OW-1:0] discard_q, discard_d;
   logic [TW-1:0] tag_rd_q, tag_rd_d;
   logic [TW-1:0] tag_wr_q, tag_wr_d;

   entry_t        queue_mem [DEPTH];
   logic [15:0]   tag_mem   [MAX_OUT];

   logic          grant;
   logic          resp;
   logic          push;
   logic          pop;
   logic [RW-1:0] reserved;
   entry_t        head;
   entry_t        push_entry;

   // The tag FIFO holds MAX_OUT entries, which need not be a power of two.
   function automatic logic [TW-1:0] next_tag(input logic [TW-1:0] ptr);
      return (ptr == TAG_LAST) ? '0 : ptr + TW'(1);
   endfunction

   // Handshake qualifiers, issue gating and decode-side outputs.
   // NOTE: every signal written in a combinational block gets a value on every path, so no latch is inferred.
   always_comb begin
      reserved   = RW'(count_q) + RW'(out_cnt_q) - RW'(discard_q);
      imem_req   = !rst && !redirect && (out_cnt_q < MAX_OUT_C) && (reserved < DEPTH_R);
      imem_addr  = fetch_pc_q;
      grant      = imem_req && imem_gnt;
      resp       = imem_rvalid && (out_cnt_q != '0);
      push       = resp && !redirect && (discard_q == '0);
      dec_valid  = (count_q != '0);
      pop        = dec_valid && dec_ready && !redirect;
      head       = queue_mem[rd_ptr_q];
      push_entry = '{pc: tag_mem[tag_rd_q], ir: imem_rdata};
      dec_pc     = dec_valid ? head.pc : 16'h0000;
      dec_ir     = dec_valid ? head.ir : 16'h0000;
      occupancy  = count_q;
   end

   // Next-state: fetch PC, in-flight bookkeeping, and queue pointers.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      out_cnt_d  = out_cnt_q + OW'(grant) - OW'(resp);
      discard_d  = discard_q;
      tag_wr_d   = grant ? next_tag(tag_wr_q) : tag_wr_q;
      tag_rd_d   = resp  ? next_tag(tag_rd_q) : tag_rd_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;

      if (redirect) begin
         // Every read still in flight after this edge is stale; the
         // same-cycle response (if any) is dropped right now.
         fetch_pc_d = redirect_pc;
         discard_d  = out_cnt_q - OW'(resp);
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (grant) begin
            fetch_pc_d = fetch_pc_q + PC_INC;
         end
         if (resp && (discard_q != '0)) begin
            discard_d = discard_q - OW'(1);
         end
         if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   // Control state register with asynchronous reset.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         out_cnt_q  <= '0;
         discard_q  <= '0;
         tag_rd_q   <= '0;
         tag_wr_q   <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         out_cnt_q  <= out_cnt_d;
         discard_q  <= discard_d;
         tag_rd_q   <= tag_rd_d;
         tag_wr_q   <= tag_wr_d;
      end
   end

   // Instruction queue and in-flight PC tag storage.
   // NOTE: storage arrays are not reset; their contents only matter where the reset pointers and counters say so.
   always_ff @(posedge clock) begin
      if (push) begin
         queue_mem[wr_ptr_q] <= push_entry;
      end
      if (grant) begin
         tag_mem[tag_wr_q] <= fetch_pc_q;
      end
   end

   // A response with no read outstanding is a memory-side protocol error.
   assert property (@(posedge clock) disable iff (rst) imem_rvalid |-> (out_cnt_q != '0));

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit.
// A memory responder grants a bounded number of reads and returns
// addr^16'hA5A5 after a programmable delay. Directed phases push the
// expected {pc, ir} stream into a scoreboard queue; a monitor pops and
// compares each time decode consumes an entry.
module tb_fetch_prefetch_unit;

   typedef struct {
      logic [15:0] pc;
      logic [15:0] ir;
   } exp_t;

   logic        clock = 1'b0;
   logic        rst;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [15:0] imem_rdata;
   logic        dec_valid;
   logic [15:0] dec_ir;
   logic [15:0] dec_pc;
   logic        dec_ready;
   logic [2:0]  occupancy;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t exp_q[$];
   int   pops = 0;
   int   last_pop_cyc = 0;
   int   cyc = 0;
   int   grants_done = 0;
   int   grant_budget = 0;
   int   resp_delay = 1;
   logic [15:0] pend_addr[$];
   int          pend_due[$];

   fetch_prefetch_unit dut (
      .clock       (clock),
      .rst         (rst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .dec_valid   (dec_valid),
      .dec_ir      (dec_ir),
      .dec_pc      (dec_pc),
      .dec_ready   (dec_ready),
      .occupancy   (occupancy)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push_exp(input logic [15:0] pc);
      exp_t e;
      e.pc = pc;
      e.ir = pc ^ 16'hA5A5;
      exp_q.push_back(e);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clock);
         #2;
      end
   endtask

   task automatic wait_pops(input int target, input int max_cycles);
      for (int k = 0; k < max_cycles && pops < target; k++) tick();
   endtask

   // Memory model: grants up to grant_budget reads, answers in order after resp_delay cycles.
   initial begin
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 16'h0000;
      forever begin
         @(negedge clock);
         if (!rst && imem_req && imem_gnt) begin
            pend_addr.push_back(imem_addr);
            pend_due.push_back(cyc + resp_delay);
            grants_done++;
         end
         @(posedge clock);
         #1;
         cyc++;
         if (rst) begin
            pend_addr.delete();
            pend_due.delete();
            imem_rvalid = 1'b0;
         end else if (pend_due.size() != 0 && pend_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend_addr.pop_front() ^ 16'hA5A5;
            void'(pend_due.pop_front());
         end else begin
            imem_rvalid = 1'b0;
         end
         imem_gnt = !rst && (grants_done < grant_budget);
      end
   end

   // Monitor: compare every consumed head against the scoreboard.
   always @(negedge clock) begin
      if (!rst) begin
         if (dec_valid && dec_ready) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_pop: got pc %h ir %h, expected no entry (t=%0t)", dec_pc, dec_ir, $time);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("dec_pc", {16'h0, dec_pc}, {16'h0, e.pc});
               check("dec_ir", {16'h0, dec_ir}, {16'h0, e.ir});
            end
            pops++;
            last_pop_cyc = cyc;
         end else if (!dec_valid) begin
            check("empty_outputs_zero", {dec_pc, dec_ir}, 32'h0);
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      exp_q.delete();
      grant_budget = grants_done;
      tick(3);
      @(negedge clock);
      check("rst_req", {31'h0, imem_req}, 32'h0);
      check("rst_valid", {31'h0, dec_valid}, 32'h0);
      check("rst_occ", {29'h0, occupancy}, 32'h0);
      @(posedge clock);
      #2;
      rst = 1'b0;
      @(negedge clock);
      check("rel_req", {31'h0, imem_req}, 32'h1);
      check("rel_addr", {16'h0, imem_addr}, 32'h0000);
   endtask

   initial begin
      int p0, g0, c1, c8;
      logic req_seen;
      rst         = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 16'h0000;
      dec_ready   = 1'b0;

      // Reset, then a steady stream of eight reads at one instruction per cycle.
      do_reset();
      tick();
      resp_delay = 1;
      dec_ready  = 1'b1;
      for (int i = 0; i < 8; i++) push_exp(16'(2 * i));
      p0 = pops;
      grant_budget = grants_done + 8;
      wait_pops(p0 + 1, 20);
      c1 = last_pop_cyc;
      wait_pops(p0 + 8, 20);
      c8 = last_pop_cyc;
      check("stream_count", pops - p0, 8);
      check("stream_rate", c8 - c1, 7);
      tick(3);
      check("stream_drained", exp_q.size(), 0);
      check("stream_occ", {29'h0, occupancy}, 32'h0);

      // Backpressure: queue fills to DEPTH and issue stops, then drains in order.
      do_reset();
      tick();
      dec_ready = 1'b0;
      g0 = grants_done;
      grant_budget = grants_done + 100;
      tick(12);
      check("bp_occ", {29'h0, occupancy}, 32'h4);
      check("bp_req", {31'h0, imem_req}, 32'h0);
      req_seen = 1'b0;
      repeat (6) begin
         tick();
         req_seen = req_seen | imem_req;
      end
      check("bp_req_hold", {31'h0, req_seen}, 32'h0);
      check("bp_grants", grants_done - g0, 4);
      grant_budget = grants_done;
      tick();
      for (int i = 0; i < 4; i++) push_exp(16'(2 * i));
      p0 = pops;
      dec_ready = 1'b1;
      wait_pops(p0 + 4, 20);
      tick(3);
      check("bp_pops", pops - p0, 4);
      check("bp_drained", exp_q.size(), 0);
      check("bp_occ_end", {29'h0, occupancy}, 32'h0);

      // Redirect with two reads in flight: both stale responses are dropped.
      do_reset();
      tick();
      resp_delay = 2;
      dec_ready  = 1'b1;
      g0 = grants_done;
      grant_budget = g0 + 2;
      for (int k = 0; k < 20 && grants_done < g0 + 2; k++) tick();
      check("rd_inflight", grants_done - g0, 2);
      p0 = pops;
      redirect    = 1'b1;
      redirect_pc = 16'h0100;
      push_exp(16'h0100);
      push_exp(16'h0102);
      grant_budget = grants_done + 2;
      tick();
      redirect = 1'b0;
      @(negedge clock);
      check("rd_addr", {16'h0, imem_addr}, 32'h0100);
      check("rd_req", {31'h0, imem_req}, 32'h1);
      check("rd_flush_valid", {31'h0, dec_valid}, 32'h0);
      wait_pops(p0 + 2, 20);
      tick(3);
      check("rd_pops", pops - p0, 2);
      check("rd_drained", exp_q.size(), 0);

      // Fetch PC wraps from 0xFFFE to 0x0000.
      resp_delay  = 1;
      p0 = pops;
      redirect    = 1'b1;
      redirect_pc = 16'hFFFE;
      push_exp(16'hFFFE);
      push_exp(16'h0000);
      grant_budget = grants_done + 2;
      tick();
      redirect = 1'b0;
      wait_pops(p0 + 2, 20);
      tick(3);
      check("wrap_pops", pops - p0, 2);
      check("wrap_drained", exp_q.size(), 0);

      // Asynchronous reset with three entries queued clears outputs before any edge.
      do_reset();
      tick();
      dec_ready  = 1'b0;
      resp_delay = 1;
      grant_budget = grants_done + 3;
      for (int k = 0; k < 20 && occupancy != 3'd3; k++) tick();
      check("ar_occ_before", {29'h0, occupancy}, 32'h3);
      check("ar_valid_before", {31'h0, dec_valid}, 32'h1);
      #1;
      rst = 1'b1;
      #1;
      check("ar_valid", {31'h0, dec_valid}, 32'h0);
      check("ar_occ", {29'h0, occupancy}, 32'h0);
      check("ar_req", {31'h0, imem_req}, 32'h0);
      check("ar_pc", {16'h0, dec_pc}, 32'h0);
      exp_q.delete();
      grant_budget = grants_done;
      tick(3);
      rst = 1'b0;
      @(negedge clock);
      check("ar_rel_addr", {16'h0, imem_addr}, 32'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Watchdog so a stuck run still terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
